le_config_loader: RTL and testbench

//   Serial chromosome loader for the logic-element array. Shifts one configuration frame in, one bit per

---
 rtl/le_cfg_if.sv | 31 +++
 rtl/le_config_loader.sv | 129 ++++++++++++
 tb/tb_le_config_loader.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/le_cfg_if.sv
// Loader handshake and configuration bus.
// master = frame source, slave = loader.
interface le_cfg_if #(
  parameter int N_LE   = 8,
  parameter int FUNC_W = 3,
  parameter int SEL_W  = 6
);
  logic                      start;
  logic                      abort;
  logic                      ser_in;
  logic                      ser_valid;
  logic                      ser_ready;
  logic [N_LE*FUNC_W-1:0]    conf_func_all;
  logic [N_LE*2*SEL_W-1:0]   conf_ins_all;
  logic                      cfg_valid;
  logic                      busy;
  logic                      done;
  logic                      err_range;

  modport master (
    output start, abort, ser_in, ser_valid,
    input  ser_ready, conf_func_all, conf_ins_all,
    input  cfg_valid, busy, done, err_range
  );

  modport slave (
    input  start, abort, ser_in, ser_valid,
    output ser_ready, conf_func_all, conf_ins_all,
    output cfg_valid, busy, done, err_range
  );
endinterface

// File: rtl/le_config_loader.sv
// Serial chromosome loader: shifts a frame in,
// range-checks selectors, commits atomically.
module le_config_loader #(
  parameter int N_LE   = 8,
  parameter int FUNC_W = 3,
  parameter int SEL_W  = 6,
  parameter int N_IN   = 33
) (
  input  logic    clk,
  input  logic    rst_n,
  le_cfg_if.slave bus
);
  localparam int LE_W  = FUNC_W + 2*SEL_W;
  localparam int FB    = N_LE * LE_W;
  localparam int CNT_W = $clog2(FB);
  localparam int FW    = N_LE * FUNC_W;
  localparam int IW    = N_LE * 2 * SEL_W;

  typedef enum logic [1:0] {
    S_IDLE, S_SHIFT, S_CHECK, S_COMMIT
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [FB-1:0]     r_shadow;
  logic [CNT_W-1:0]  r_cnt;
  logic [FW-1:0]     r_func;
  logic [IW-1:0]     r_ins;
  logic              r_cfg_valid;
  logic              r_done;
  logic              r_err;
  logic              w_accept;
  logic              w_last;
  logic              w_legal;
  logic [FW-1:0]     w_func;
  logic [IW-1:0]     w_ins;

  assign w_accept = (r_state == S_SHIFT)
                  && bus.ser_valid && !bus.abort;
  assign w_last   = (r_cnt == CNT_W'(FB-1));

  // Next-state: abort wins over an accepted bit.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (bus.start) w_next = S_SHIFT;
      S_SHIFT:
        if (bus.abort) w_next = S_IDLE;
        else if (w_accept && w_last)
          w_next = S_CHECK;
      S_CHECK:
        w_next = bus.abort ? S_IDLE : S_COMMIT;
      S_COMMIT:
        w_next = S_IDLE;
      default:
        w_next = S_IDLE;
    endcase
  end

  // Unpack shadow into per-LE fields and range-check.
  always_comb begin
    w_legal = 1'b1;
    w_func  = '0;
    w_ins   = '0;
    for (int k = 0; k < N_LE; k++) begin
      w_func[k*FUNC_W +: FUNC_W] =
        r_shadow[k*LE_W +: FUNC_W];
      w_ins[k*2*SEL_W +: 2*SEL_W] =
        r_shadow[k*LE_W+FUNC_W +: 2*SEL_W];
      for (int j = 0; j < 2; j++) begin
        if ({1'b0, r_shadow[k*LE_W+FUNC_W+j*SEL_W +: SEL_W]}
            >= (SEL_W+1)'(N_IN))
          w_legal = 1'b0;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Shadow shift register and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
      r_cnt    <= '0;
    end else if (r_state == S_IDLE && bus.start) begin
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_shadow <= {bus.ser_in, r_shadow[FB-1:1]};
      r_cnt    <= r_cnt + 1'b1;
    end
  end

  // Active config, status flags and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_func      <= '0;
      r_ins       <= '0;
      r_cfg_valid <= 1'b0;
      r_err       <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= (w_next == S_COMMIT);
      if (r_state == S_IDLE && bus.start)
        r_err <= 1'b0;
      if (r_state == S_CHECK && !bus.abort) begin
        if (w_legal) begin
          r_func      <= w_func;
          r_ins       <= w_ins;
          r_cfg_valid <= 1'b1;
        end else begin
          r_err       <= 1'b1;
        end
      end
    end
  end

  assign bus.ser_ready     = (r_state == S_SHIFT);
  assign bus.busy          = (r_state != S_IDLE);
  assign bus.done          = r_done;
  assign bus.conf_func_all = r_func;
  assign bus.conf_ins_all  = r_ins;
  assign bus.cfg_valid     = r_cfg_valid;
  assign bus.err_range     = r_err;
endmodule

// File: tb/tb_le_config_loader.sv
// Bench for le_config_loader: frame stimulus,
// reference model and done-driven scoreboard.
module tb_le_config_loader;
  localparam int N_LE = 8;
  localparam int FB   = 120;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  le_cfg_if #(.N_LE(8), .FUNC_W(3), .SEL_W(6)) bus();

  le_config_loader #(
    .N_LE(8), .FUNC_W(3), .SEL_W(6), .N_IN(33)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [23:0] func;
    logic [95:0] ins;
    logic        cfg;
    logic        err;
    int          dcyc;
  } exp_t;
  exp_t q[$];

  logic [23:0] m_func = '0;
  logic [95:0] m_ins  = '0;
  logic        m_cfg  = 1'b0;
  logic        m_err  = 1'b0;
  logic [14:0] fw[N_LE];

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic set_le(input int k, input int sa,
                        input int sb, input int f);
    fw[k] = {6'(sb), 6'(sa), 3'(f)};
  endtask

  // Model of a finished frame: commit only if every
  // selector is below 33.
  task automatic push_frame();
    exp_t e;
    logic ok;
    ok = 1'b1;
    for (int k = 0; k < N_LE; k++) begin
      if (int'(fw[k][8:3]) > 32)  ok = 1'b0;
      if (int'(fw[k][14:9]) > 32) ok = 1'b0;
    end
    if (ok) begin
      for (int k = 0; k < N_LE; k++) begin
        m_func[k*3 +: 3]  = fw[k][2:0];
        m_ins[k*12 +: 12] = fw[k][14:3];
      end
      m_cfg = 1'b1;
    end
    m_err  = !ok;
    e.func = m_func;
    e.ins  = m_ins;
    e.cfg  = m_cfg;
    e.err  = m_err;
    e.dcyc = cyc + 1;
    q.push_back(e);
  endtask

  task automatic chk_hold(input string nm);
    chk({nm, "_func"}, bus.conf_func_all, m_func);
    chk({nm, "_ins"},  bus.conf_ins_all,  m_ins);
    chk({nm, "_cfg"},  bus.cfg_valid,     m_cfg);
    chk({nm, "_err"},  bus.err_range,     m_err);
  endtask

  // gap: 0 none, 1 alternate, 2 random.
  // abort_at == FB aborts in the check cycle.
  task automatic run_frame(input int gap,
                           input int abort_at,
                           input int start_at,
                           input int rst_at);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    m_err = 1'b0;
    chk("err_clear_on_start", bus.err_range, 1'b0);
    chk("busy_after_start", bus.busy, 1'b1);
    for (int i = 0; i < FB; i++) begin
      if (i == abort_at) begin
        bus.ser_valid = 1'b1;
        bus.ser_in    = 1'($urandom);
        bus.abort     = 1'b1;
        @(posedge clk); #1;
        bus.abort     = 1'b0;
        bus.ser_valid = 1'b0;
        chk("abort_busy", bus.busy, 1'b0);
        chk_hold("abort_hold");
        return;
      end
      if (i == rst_at) begin
        rst_n = 1'b0;
        #1;
        m_func = '0; m_ins = '0;
        m_cfg  = 1'b0; m_err = 1'b0;
        chk_hold("rst_mid");
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_ready", bus.ser_ready, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        bus.ser_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        return;
      end
      if ((gap == 1 && i % 2 == 1) ||
          (gap == 2 && $urandom_range(0, 3) == 0)) begin
        bus.ser_valid = 1'b0;
        chk("ready_in_gap", bus.ser_ready, 1'b1);
        @(posedge clk); #1;
      end
      bus.ser_valid = 1'b1;
      bus.ser_in    = fw[i / 15][i % 15];
      bus.start     = (i == start_at);
      @(posedge clk); #1;
      bus.ser_valid = 1'b0;
      bus.start     = 1'b0;
    end
    if (abort_at == FB) begin
      bus.abort = 1'b1;
      @(posedge clk); #1;
      bus.abort = 1'b0;
      chk("abort_chk_busy", bus.busy, 1'b0);
      chk_hold("abort_chk_hold");
    end else begin
      push_frame();
      repeat (3) @(posedge clk);
      #1;
      chk("err_hold", bus.err_range, m_err);
      chk("idle_after", bus.busy, 1'b0);
    end
  endtask

  task automatic t1_frame();
    for (int k = 0; k < N_LE; k++) set_le(k, k, k+1, k);
  endtask

  task automatic rand_frame(input bit bad);
    for (int k = 0; k < N_LE; k++)
      set_le(k, $urandom_range(0, 32),
             $urandom_range(0, 32), $urandom_range(0, 7));
    if (bad) begin
      if ($urandom_range(0, 1) == 0)
        fw[$urandom_range(0, 7)][8:3]  = 6'($urandom_range(33, 63));
      else
        fw[$urandom_range(0, 7)][14:9] = 6'($urandom_range(33, 63));
    end
  endtask

  // Monitor: pops expectations whenever done is seen,
  // and checks the active outputs stay put while shifting.
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.done) begin
        chk("done_one_cycle", prev_done, 1'b0);
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got 1 expected 0");
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("done_latency", cyc, e.dcyc);
          chk("conf_func_all", bus.conf_func_all, e.func);
          chk("conf_ins_all", bus.conf_ins_all, e.ins);
          chk("cfg_valid", bus.cfg_valid, e.cfg);
          chk("err_range", bus.err_range, e.err);
        end
      end
      if (bus.ser_ready) begin
        chk("shift_hold_func", bus.conf_func_all, m_func);
        chk("shift_hold_ins", bus.conf_ins_all, m_ins);
      end
    end
    prev_done <= bus.done;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.ser_in    = 1'b0;
    bus.ser_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_hold("reset");
    chk("reset_done", bus.done, 1'b0);
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_ready", bus.ser_ready, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    t1_frame();
    run_frame(0, -1, -1, -1);
    run_frame(1, -1, -1, -1);
    set_le(5, 33, 6, 5);
    run_frame(0, -1, -1, -1);
    rand_frame(1'b0);
    run_frame(0, 50, -1, -1);
    run_frame(0, -1, -1, -1);
    rand_frame(1'b0);
    run_frame(2, FB, -1, -1);
    t1_frame();
    run_frame(0, -1, 30, -1);
    for (int n = 0; n < 6; n++) begin
      rand_frame($urandom_range(0, 3) == 0);
      run_frame(2, -1, -1, -1);
    end
    rand_frame(1'b0);
    run_frame(0, -1, -1, -1);
    rand_frame(1'b0);
    run_frame(0, -1, -1, 70);
    t1_frame();
    run_frame(2, -1, -1, -1);

    repeat (5) @(posedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end
endmodule
